// File: rtl/tx_event_fifo_if.sv
// tx_event_fifo_if: comms_ctrl write side and uart_tx load/busy handshake of the event FIFO.
interface tx_event_fifo_if #(
    parameter int WIDTH      = 54,
    parameter int ADDR_WIDTH = 4
);
    logic                  write_fifo_n;
    logic [WIDTH-1:0]      fifo_data_in;
    logic                  tx_busy;
    logic                  clr_overflow;
    logic [WIDTH-1:0]      tx_data;
    logic                  ld_tx_data;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ADDR_WIDTH:0]   fifo_counter;
    logic                  overflow;
    modport master (
        output write_fifo_n, fifo_data_in, tx_busy, clr_overflow,
        input  tx_data, ld_tx_data, fifo_empty, fifo_full, fifo_counter, overflow
    );
    modport slave (
        input  write_fifo_n, fifo_data_in, tx_busy, clr_overflow,
        output tx_data, ld_tx_data, fifo_empty, fifo_full, fifo_counter, overflow
    );
endinterface

// File: rtl/tx_event_fifo.sv
// tx_event_fifo: circular buffer of event words, handed to uart_tx one at a time
// through a registered ld_tx_data strobe paced by tx_busy.
module tx_event_fifo #(
    parameter int WIDTH      = 54,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input logic              clk,
    input logic              reset,
    tx_event_fifo_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, DRAIN} state_e;
    state_e                state_q, state_d;
    logic                  hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      tx_data_q;
    logic                  ld_q, ovf_q;
    logic                  empty, full, push, drop, pop;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == (ADDR_WIDTH+1)'(DEPTH);
    // full is judged on the pre-edge count, so a same-edge pop never rescues a write
    assign push  = !bus.write_fifo_n && !full;
    assign drop  = !bus.write_fifo_n && full;
    assign pop   = state_q == IDLE && !empty && !bus.tx_busy;
    assign cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE:  if (pop) state_d = LOAD;
            LOAD:  begin
                state_d = HOLD;
                hold_d  = 1'b0;
            end
            // uart_tx raises tx_busy a cycle late, so ignore it for two cycles
            HOLD:  begin
                hold_d = 1'b1;
                if (hold_q) state_d = DRAIN;
            end
            DRAIN: if (!bus.tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            ld_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            ld_q     <= pop;
            ovf_q    <= drop ? 1'b1 : bus.clr_overflow ? 1'b0 : ovf_q;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                tx_data_q <= mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr_q] <= bus.fifo_data_in;
    end

    assign bus.tx_data      = tx_data_q;
    assign bus.ld_tx_data   = ld_q;
    assign bus.fifo_empty   = empty;
    assign bus.fifo_full    = full;
    assign bus.fifo_counter = cnt_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_tx_event_fifo.sv
// tb_tx_event_fifo: directed vectors for tx_event_fifo with a simple uart_tx busy model.
module tb_tx_event_fifo;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    logic model_en = 1'b0;
    logic busy_force = 1'b0;
    logic [63:0] got [$];
    int          ld_cyc [$];
    int          b;

    tx_event_fifo_if #(.WIDTH(54), .ADDR_WIDTH(4)) bus ();
    tx_event_fifo #(.WIDTH(54), .DEPTH(16), .ADDR_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;
    assign bus.tx_busy = busy_force || busy_cnt != 0;

    // uart_tx stand-in: captures on ld_tx_data and stays busy for 20 cycles
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.ld_tx_data) begin
            got.push_back(64'(bus.tx_data));
            ld_cyc.push_back(cyc);
            busy_cnt <= model_en ? 20 : 0;
        end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [53:0] d);
        bus.write_fifo_n = 1'b0;
        bus.fifo_data_in = d;
        step();
        bus.write_fifo_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        bus.write_fifo_n = 1'b1;
        bus.fifo_data_in = '0;
        bus.clr_overflow = 1'b0;
        step(2);
        reset = 1'b0;
        check("rst_empty", 64'(bus.fifo_empty), 1);
        check("rst_full", 64'(bus.fifo_full), 0);
        check("rst_cnt", 64'(bus.fifo_counter), 0);
        check("rst_ld", 64'(bus.ld_tx_data), 0);
        check("rst_txd", 64'(bus.tx_data), 0);
        check("rst_ovf", 64'(bus.overflow), 0);

        // 1: single word latency
        write(54'h2A_5555_AAAA_0102);
        check("t1_empty", 64'(bus.fifo_empty), 0);
        check("t1_cnt1", 64'(bus.fifo_counter), 1);
        check("t1_ld0", 64'(bus.ld_tx_data), 0);
        step();
        check("t1_ld1", 64'(bus.ld_tx_data), 1);
        check("t1_txd", 64'(bus.tx_data), 64'h2A_5555_AAAA_0102);
        check("t1_cnt0", 64'(bus.fifo_counter), 0);
        step();
        check("t1_ld_once", 64'(bus.ld_tx_data), 0);
        check("t1_txd_hold", 64'(bus.tx_data), 64'h2A_5555_AAAA_0102);
        step(6);

        // 2: three words with tx_busy high 20 cycles per load
        model_en = 1'b1;
        b = got.size();
        write(54'h1);
        write(54'h2);
        write(54'h3);
        step(80);
        check("t2_n", 64'(got.size() - b), 3);
        if (got.size() - b == 3) begin
            for (int i = 0; i < 3; i++) check("t2_word", got[b+i], 64'(i + 1));
            check("t2_gap1", 64'(ld_cyc[b+1] - ld_cyc[b]), 22);
            check("t2_gap2", 64'(ld_cyc[b+2] - ld_cyc[b+1]), 22);
        end
        model_en = 1'b0;

        // 3: fill with tx_busy held, overflow on 17th
        busy_force = 1'b1;
        step(2);
        for (int i = 0; i < 16; i++) write(54'(i));
        check("t3_full", 64'(bus.fifo_full), 1);
        check("t3_cnt16", 64'(bus.fifo_counter), 16);
        check("t3_ovf0", 64'(bus.overflow), 0);
        write(54'd16);
        check("t3_ovf1", 64'(bus.overflow), 1);
        check("t3_cnt_keep", 64'(bus.fifo_counter), 16);
        b = got.size();
        busy_force = 1'b0;
        step(95);
        check("t3_n", 64'(got.size() - b), 16);
        if (got.size() - b == 16)
            for (int i = 0; i < 16; i++) check("t3_word", got[b+i], 64'(i));
        check("t3_empty", 64'(bus.fifo_empty), 1);

        // 4: pop edge coincides with a write while full; set beats clear
        bus.clr_overflow = 1'b1;
        step();
        bus.clr_overflow = 1'b0;
        check("t4_clr", 64'(bus.overflow), 0);
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) write(54'(100 + i));
        b = got.size();
        busy_force = 1'b0;
        bus.clr_overflow = 1'b1;
        write(54'hBEEF);
        bus.clr_overflow = 1'b0;
        check("t4_ovf_set", 64'(bus.overflow), 1);
        check("t4_cnt15", 64'(bus.fifo_counter), 15);
        check("t4_ld", 64'(bus.ld_tx_data), 1);
        bus.clr_overflow = 1'b1;
        step();
        bus.clr_overflow = 1'b0;
        check("t4_ovf_clr", 64'(bus.overflow), 0);
        step(90);
        check("t4_n", 64'(got.size() - b), 16);
        if (got.size() - b == 16) begin
            check("t4_first", got[b], 100);
            check("t4_last", got[b+15], 115);
        end

        // 5: simultaneous push and pop at count 1
        busy_force = 1'b1;
        write(54'h55);
        busy_force = 1'b0;
        write(54'h66);
        check("t5_cnt", 64'(bus.fifo_counter), 1);
        check("t5_txd", 64'(bus.tx_data), 64'h55);
        b = got.size();
        step(20);
        check("t5_n", 64'(got.size() - b), 2);
        if (got.size() - b == 2) check("t5_next", got[b+1], 64'h66);

        // 6: reset while draining with 4 words stored
        model_en = 1'b1;
        for (int i = 0; i < 5; i++) write(54'(200 + i));
        step(3);
        check("t6_cnt4", 64'(bus.fifo_counter), 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_cnt0", 64'(bus.fifo_counter), 0);
        check("t6_empty", 64'(bus.fifo_empty), 1);
        check("t6_ld", 64'(bus.ld_tx_data), 0);
        check("t6_txd", 64'(bus.tx_data), 0);
        b = got.size();
        step(30);
        check("t6_quiet", 64'(got.size() - b), 0);
        write(54'h77);
        step(10);
        check("t6_n", 64'(got.size() - b), 1);
        if (got.size() - b == 1) check("t6_word", got[b], 64'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
